// File: rtl/slave_port_arbiter_pkg.sv
// Shared crossbar definitions: default widths, arbiter state encoding and command values.
// Also holds a small wrap-around increment helper.
package slave_port_arbiter_pkg;

  localparam int unsigned DefaultDataW = 32;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  localparam logic CmdRead  = 1'b0;
  localparam logic CmdWrite = 1'b1;

  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/slave_port_arbiter_if.sv
// Bus bundle between the master-side routing, one slave-port arbiter and the slave interface.
interface slave_port_arbiter_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned DATA_W    = 32
);

  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS*DATA_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_cmd;
  logic [N_MASTERS-1:0]        m_ack;
  logic [N_MASTERS*DATA_W-1:0] m_rdata;

  logic                        req_from_crossbar;
  logic [DATA_W-1:0]           addr_from_crossbar;
  logic [DATA_W-1:0]           wdata_from_crossbar;
  logic                        cmd_from_crossbar;
  logic                        connect_approved_from_crossbar;
  logic                        ack_to_crossbar;
  logic [DATA_W-1:0]           rdata_to_crossbar;

  // Environment view: requesting masters plus the downstream slave model.
  modport master (
    output m_req, m_addr, m_wdata, m_cmd, ack_to_crossbar, rdata_to_crossbar,
    input  m_ack, m_rdata, req_from_crossbar, addr_from_crossbar, wdata_from_crossbar,
           cmd_from_crossbar, connect_approved_from_crossbar
  );

  // Arbiter view.
  modport slave (
    input  m_req, m_addr, m_wdata, m_cmd, ack_to_crossbar, rdata_to_crossbar,
    output m_ack, m_rdata, req_from_crossbar, addr_from_crossbar, wdata_from_crossbar,
           cmd_from_crossbar, connect_approved_from_crossbar
  );

endinterface

// File: rtl/slave_port_arbiter_rr_select.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping.
module slave_port_arbiter_rr_select #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  logic [N_MASTERS-1:0] rotated;
  logic [IDX_W:0]       offset;
  logic [IDX_W:0]       sum;

  always_comb begin
    // Rotate so that bit 0 is the master at ptr; the lowest set bit is then the winner.
    rotated = N_MASTERS'({req, req} >> ptr);
    offset  = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = (IDX_W + 1)'(k);
      end
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= (IDX_W + 1)'(N_MASTERS)) begin
      sum = sum - (IDX_W + 1)'(N_MASTERS);
    end
    idx   = sum[IDX_W-1:0];
    valid = |req;
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave round-robin arbiter: grants one master at a time onto the slave port and routes
// the slave ack/read data back to the owner only.
module slave_port_arbiter
  import slave_port_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  parameter int unsigned DATA_W    = DefaultDataW
) (
  input  logic                 clk,
  input  logic                 rst,
  slave_port_arbiter_if.slave  bus,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic             busy_q;
  logic             conn_q;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             in_grant;

  logic              g_req;
  logic              g_cmd;
  logic [DATA_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  slave_port_arbiter_rr_select #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req   (bus.m_req),
    .ptr   (rr_ptr_q),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  assign in_grant = (state_q == StGrant);

  // Fields of the currently granted master.
  always_comb begin
    g_req   = 1'b0;
    g_cmd   = CmdRead;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        g_req   = bus.m_req[i];
        g_cmd   = bus.m_cmd[i];
        g_addr  = bus.m_addr[i*DATA_W +: DATA_W];
        g_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.req_from_crossbar              = in_grant & g_req;
    bus.cmd_from_crossbar              = in_grant & g_cmd;
    bus.addr_from_crossbar             = in_grant ? g_addr : '0;
    bus.wdata_from_crossbar            = in_grant ? g_wdata : '0;
    bus.connect_approved_from_crossbar = conn_q;
    bus.m_ack                          = '0;
    bus.m_rdata                        = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (in_grant && grant_idx_q == IDX_W'(i)) begin
        bus.m_ack[i] = bus.ack_to_crossbar;
        if (bus.ack_to_crossbar && g_cmd == CmdRead) begin
          bus.m_rdata[i*DATA_W +: DATA_W] = bus.rdata_to_crossbar;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      busy_q      <= 1'b0;
      conn_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sel_valid) begin
            state_q     <= StGrant;
            grant_idx_q <= sel_idx;
            busy_q      <= 1'b1;
            conn_q      <= 1'b1;
          end
        end
        StGrant: begin
          // Completion or abort both release the port and move priority past the owner.
          if (bus.ack_to_crossbar || !g_req) begin
            state_q  <= StIdle;
            rr_ptr_q <= IDX_W'(wrap_inc(32'(grant_idx_q), N_MASTERS));
            busy_q   <= 1'b0;
            conn_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_idx = grant_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed bench for slave_port_arbiter with a per-cycle reference model and literal pins.
module tb_slave_port_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] grant_idx;
  logic       busy;

  always #5 clk = ~clk;

  slave_port_arbiter_if #(.N_MASTERS(N), .DATA_W(DW)) bus ();

  slave_port_arbiter #(
    .N_MASTERS (N),
    .IDX_W     (1),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: who owns the port (-1 = nobody), where the round-robin search starts,
  // and the most recent grant (visible on grant_idx while idle).
  int owner = -1;
  int ptr   = 0;
  int last  = 0;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      owner <= -1;
      ptr   <= 0;
      last  <= 0;
    end else if (owner < 0) begin
      if (bus.m_req != '0) begin
        owner <= pick(bus.m_req, ptr);
        last  <= pick(bus.m_req, ptr);
      end
    end else if (bus.ack_to_crossbar || !bus.m_req[owner]) begin
      owner <= -1;
      ptr   <= (owner + 1) % N;
    end
  end

  always @(negedge clk) begin
    logic [63:0]   e_rdata;
    logic [N-1:0]  e_ack;
    logic          e_req, e_cmd;
    logic [DW-1:0] e_addr, e_wdata;
    if (chk_en) begin
      e_req = 0; e_cmd = 0; e_addr = '0; e_wdata = '0; e_ack = '0; e_rdata = '0;
      if (owner >= 0) begin
        e_req   = bus.m_req[owner];
        e_cmd   = bus.m_cmd[owner];
        e_addr  = bus.m_addr[owner*DW +: DW];
        e_wdata = bus.m_wdata[owner*DW +: DW];
        if (bus.ack_to_crossbar) begin
          e_ack = N'(1) << owner;
          if (!e_cmd) e_rdata = {32'b0, bus.rdata_to_crossbar} << (owner * DW);
        end
      end
      check("model_grant_idx", 64'(grant_idx), (owner >= 0) ? 64'(owner) : 64'(last));
      check("model_busy", 64'(busy), 64'(owner >= 0));
      check("model_conn", 64'(bus.connect_approved_from_crossbar), 64'(owner >= 0));
      check("model_req", 64'(bus.req_from_crossbar), 64'(e_req));
      check("model_cmd", 64'(bus.cmd_from_crossbar), 64'(e_cmd));
      check("model_addr", 64'(bus.addr_from_crossbar), 64'(e_addr));
      check("model_wdata", 64'(bus.wdata_from_crossbar), 64'(e_wdata));
      check("model_m_ack", 64'(bus.m_ack), 64'(e_ack));
      check("model_m_rdata", bus.m_rdata, e_rdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic set_master(input int i, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                            input logic c);
    bus.m_addr[i*DW +: DW]  = a;
    bus.m_wdata[i*DW +: DW] = wd;
    bus.m_cmd[i]            = c;
  endtask

  int exp_seq[4] = '{0, 1, 0, 1};

  initial begin
    bus.m_req = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_cmd = '0;
    bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0;
    tick;
    chk_en = 1'b1;
    settle;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_grant_idx", 64'(grant_idx), 64'd0);
    check("reset_conn", 64'(bus.connect_approved_from_crossbar), 64'd0);
    tick;
    rst = 1'b0;

    // Single read from m0.
    set_master(0, 32'h10, 32'h0, 1'b0);
    bus.m_req = 2'b01;
    settle;
    check("read_idle_req", 64'(bus.req_from_crossbar), 64'd0);
    tick;
    settle;
    check("read_slave_req", 64'(bus.req_from_crossbar), 64'd1);
    check("read_slave_addr", 64'(bus.addr_from_crossbar), 64'h10);
    tick;
    bus.ack_to_crossbar = 1'b1; bus.rdata_to_crossbar = 32'hDEADBEEF;
    settle;
    check("read_m_ack", 64'(bus.m_ack), 64'b01);
    check("read_m_rdata", bus.m_rdata, 64'h0000_0000_DEAD_BEEF);
    tick;
    bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0; bus.m_req = 2'b00;
    settle;
    check("read_back_idle", 64'(busy), 64'd0);

    // Write from m1; slave drives junk rdata that must not leak.
    set_master(1, 32'h20, 32'h12345678, 1'b1);
    bus.m_req = 2'b10;
    tick;
    settle;
    check("write_addr", 64'(bus.addr_from_crossbar), 64'h20);
    check("write_wdata", 64'(bus.wdata_from_crossbar), 64'h12345678);
    check("write_cmd", 64'(bus.cmd_from_crossbar), 64'd1);
    check("write_conn", 64'(bus.connect_approved_from_crossbar), 64'd1);
    bus.ack_to_crossbar = 1'b1; bus.rdata_to_crossbar = 32'hCAFEF00D;
    settle;
    check("write_m_ack", 64'(bus.m_ack), 64'b10);
    check("write_m_rdata", bus.m_rdata, 64'd0);
    tick;
    bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0; bus.m_req = 2'b00;

    // Contention: both masters always requesting, slave acks one cycle into each grant.
    set_master(0, 32'h100, 32'h0, 1'b0);
    set_master(1, 32'h104, 32'h0, 1'b0);
    bus.m_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick;
      tick;
      bus.ack_to_crossbar = 1'b1; bus.rdata_to_crossbar = 32'hA000_0000 + 32'(t);
      settle;
      check("contention_grant", 64'(grant_idx), 64'(exp_seq[t]));
      check("contention_m_ack", 64'(bus.m_ack), 64'(2'b01 << exp_seq[t]));
      tick;
      bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0;
    end
    bus.m_req = 2'b00;

    // Late request from m1 while m0 owns the port.
    bus.m_req = 2'b01;
    tick;
    bus.m_req = 2'b11;
    tick;
    settle;
    check("late_grant_held", 64'(grant_idx), 64'd0);
    check("late_addr_held", 64'(bus.addr_from_crossbar), 64'h100);
    bus.ack_to_crossbar = 1'b1; bus.rdata_to_crossbar = 32'h1111;
    settle;
    check("late_m_ack", 64'(bus.m_ack), 64'b01);
    tick;
    bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0; bus.m_req = 2'b10;
    settle;
    check("late_idle_gap", 64'(busy), 64'd0);
    tick;
    settle;
    check("late_m1_granted", 64'(grant_idx), 64'd1);
    bus.ack_to_crossbar = 1'b1;
    tick;
    bus.ack_to_crossbar = 1'b0; bus.m_req = 2'b00;

    // Abort by m0, then a stray ack while idle.
    bus.m_req = 2'b01;
    tick;
    tick;
    bus.m_req = 2'b00;
    settle;
    check("abort_m_ack", 64'(bus.m_ack), 64'd0);
    check("abort_slave_req", 64'(bus.req_from_crossbar), 64'd0);
    tick;
    bus.ack_to_crossbar = 1'b1; bus.rdata_to_crossbar = 32'h55;
    settle;
    check("stray_m_ack", 64'(bus.m_ack), 64'd0);
    check("stray_m_rdata", bus.m_rdata, 64'd0);
    tick;
    bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0;
    settle;
    check("stray_still_idle", 64'(busy), 64'd0);
    bus.m_req = 2'b11;
    tick;
    settle;
    check("abort_prefers_m1", 64'(grant_idx), 64'd1);

    // Reset mid-grant, followed by a late slave ack that must be ignored.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.ack_to_crossbar = 1'b1; bus.rdata_to_crossbar = 32'h77;
    settle;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_conn", 64'(bus.connect_approved_from_crossbar), 64'd0);
    check("rst_grant_idx", 64'(grant_idx), 64'd0);
    check("rst_slave_req", 64'(bus.req_from_crossbar), 64'd0);
    check("rst_m_ack", 64'(bus.m_ack), 64'd0);
    check("rst_m_rdata", bus.m_rdata, 64'd0);
    tick;
    bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0;
    settle;
    check("rst_then_m0", 64'(grant_idx), 64'd0);
    check("rst_then_busy", 64'(busy), 64'd1);
    bus.ack_to_crossbar = 1'b1; bus.rdata_to_crossbar = 32'h99;
    tick;
    bus.ack_to_crossbar = 1'b0; bus.rdata_to_crossbar = '0; bus.m_req = 2'b00;
    tick;
    tick;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_port_arbiter.md
Name: slave_port_arbiter

Overview:
- Per-slave arbiter in the crossbar. It shares one slave port between N_MASTERS requesters using round-robin order.
- It sequences one transaction at a time into the downstream slave interface: it drives the muxed req/addr/wdata/cmd plus connect_approved, then routes ack/rdata back to the granted master only.
- The crossbar instantiates one per slave, between the master-side routing and the slave interface block.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8)
- IDX_W, 1, grant index width, equal to clog2(N_MASTERS), minimum 1
- DATA_W, 32, address/data width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- m_req  input  N_MASTERS  per-master request, held high until that master sees its ack
- m_addr  input  N_MASTERS*DATA_W  flattened addresses; master i uses bits [i*DATA_W +: DATA_W]
- m_wdata  input  N_MASTERS*DATA_W  flattened write data
- m_cmd  input  N_MASTERS  1 = write, 0 = read
- m_ack  output  N_MASTERS  per-master ack; one-hot or zero
- m_rdata  output  N_MASTERS*DATA_W  flattened read data; zero for non-granted masters
- req_from_crossbar  output  1  request to slave interface
- addr_from_crossbar  output  DATA_W  muxed address
- wdata_from_crossbar  output  DATA_W  muxed write data
- cmd_from_crossbar  output  1  muxed command
- connect_approved_from_crossbar  output  1  high while a master owns the port
- ack_to_crossbar  input  1  slave ack, 1-cycle pulse
- rdata_to_crossbar  input  DATA_W  slave read data, valid with ack
- grant_idx  output  IDX_W  currently or last granted master (debug)
- busy  output  1  high in GRANT state

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, busy=0, connect_approved=0, req/cmd=0, addr/wdata=0, m_ack=0, m_rdata=0.
- IDLE:
  - If m_req is nonzero, select the first set bit searching upward from rr_ptr, wrapping modulo N_MASTERS.
  - Register it in grant_idx and go to GRANT.
  - Slave-side outputs stay at 0 during IDLE.
- GRANT:
  - connect_approved=1 and busy=1.
  - req/addr/wdata/cmd_from_crossbar combinationally equal the granted master's fields.
  - Arbitration latency: master request in cycle 0 appears at the slave port in cycle 1.
- Ack path (combinational, same cycle as ack_to_crossbar):
  - m_ack[grant_idx] = ack_to_crossbar in GRANT.
  - m_rdata slice grant_idx = rdata_to_crossbar when cmd=read; otherwise zero.
  - All other slices are zero.
- GRANT to IDLE on ack_to_crossbar:
  - rr_ptr <= grant_idx+1, wrapping to 0 at N_MASTERS.
  - There is always one IDLE cycle between transactions. Back-to-back requests from the same master are therefore re-arbitrated fairly.
- Abort: in GRANT with m_req[grant_idx]=0 and no ack, return to IDLE next cycle.
  - rr_ptr is still advanced.
  - No m_ack is generated.
- Ack received in IDLE is ignored: no m_ack, no state change.
- Grant ownership:
  - Requests from non-granted masters during GRANT never change grant_idx or the slave-side outputs.
  - Those masters see m_ack=0.
- Simultaneous requests: round-robin only, with no fixed priority beyond the rr_ptr start point.
- Reset asserted mid-GRANT: next cycle all outputs return to their reset values and rr_ptr=0. An in-flight slave ack after reset is ignored.
- Write transactions: m_rdata stays zero even if the slave drives rdata.

Decomposition:
- Shared package/include `crossbar_defs`: DATA_W, state encodings (ST_IDLE=0, ST_GRANT=1), CMD_READ=0 and CMD_WRITE=1.
- One natural sub-module, `rr_select`:
  - Combinational round-robin first-set-bit finder.
  - Inputs: req vector and rr_ptr. Outputs: index and valid.
  - Reusable by the master-side arbiters.

Test Plan:
- Single read: m0 req, addr=0x10, cmd=0; slave acks 2 cycles later with rdata=0xDEADBEEF.
  - Slave req is high from cycle 1.
  - m_ack[0] pulses once with m_rdata[31:0]=0xDEADBEEF; m_rdata[63:32]=0.
  - State returns to IDLE.
- Write: m1 req, cmd=1, addr=0x20, wdata=0x12345678.
  - Slave sees addr=0x20, wdata=0x12345678, cmd=1 and connect_approved=1.
  - On ack, m_ack[1]=1 and m_rdata=0.
- Contention: m0 and m1 both hold req continuously, slave acks every transaction after 1 cycle.
  - Grants alternate 0,1,0,1.
  - Neither master is granted twice in a row.
- Late request: m1 raises req while m0 is in GRANT.
  - grant_idx stays 0 until m0's ack.
  - m1 is granted after the IDLE cycle.
- Abort and stray ack: m0 drops req mid-GRANT → IDLE with no m_ack, and the next grant prefers m1. A stray ack in IDLE → no m_ack.
- Reset mid-GRANT: all outputs are 0 the following cycle with rr_ptr=0; the next simultaneous m0/m1 request grants m0.
